ctrl_rx_frame: RTL and testbench



---
 rtl/ctrl_rx_frame.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_ctrl_rx_frame.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_rx_frame.sv
// -----------------------------------------------------------------------------
// ctrl_rx_frame
//
// Receiver for the 485 control line. It decodes UART-style bytes from rx_ctrl,
// collects 6-byte command frames (HEAD, dev, mod, addr, data, checksum) and
// checks the header, the checksum and the device address. An accepted frame
// updates the command outputs and pulses cmd_vld for one cycle.
//
// Compile-time option:
//   CTRL_RX_BROADCAST_EN - when defined, dev byte 8'hFF is accepted in
//                          addition to cfg_dev_id.
//
// Parameters:
//   BIT_DIV  - clk_sys cycles per serial bit (must be >= 8)
//   TIMEOUT  - maximum idle clk_sys cycles between bytes inside a frame
//   HEAD     - frame header byte
//
// Ports:
//   clk_sys    in   system clock
//   rst_n      in   asynchronous active-low reset
//   rx_ctrl    in   serial control line, idle high, asynchronous to clk_sys
//   cfg_dev_id in   [7:0] device address of this slave (static after reset)
//   dev_id     out  [7:0] device id of the last accepted frame
//   mod_id     out  [7:0] module id of the last accepted frame
//   cmd_addr   out  [7:0] register address of the last accepted frame
//   cmd_data   out  [7:0] register data of the last accepted frame
//   cmd_vld    out  one-cycle strobe, frame accepted
//   err_chk    out  one-cycle strobe, checksum mismatch
//   err_frm    out  one-cycle strobe, stop-bit (framing) error
// -----------------------------------------------------------------------------
module ctrl_rx_frame #(
    parameter int          BIT_DIV = 100,
    parameter int          TIMEOUT = 2000,
    parameter logic [7:0]  HEAD    = 8'hAA
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       rx_ctrl,
    input  logic [7:0] cfg_dev_id,
    output logic [7:0] dev_id,
    output logic [7:0] mod_id,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       cmd_vld,
    output logic       err_chk,
    output logic       err_frm
);

    localparam int CNT_W = $clog2(BIT_DIV);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP
    } bit_state_t;

    typedef enum logic [2:0] {
        F_WAIT_HEAD,
        F_DEV,
        F_MOD,
        F_ADDR,
        F_DATA,
        F_CHK
    } frm_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser plus one extra stage for falling-edge detection.
    // All of these idle high so reset never looks like a start bit.
    // ------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_ctrl;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // ------------------------------------------------------------------
    // Bit FSM
    // ------------------------------------------------------------------
    bit_state_t        bit_state_q, bit_state_d;
    logic [CNT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [2:0]        bit_idx_q,   bit_idx_d;
    logic [7:0]        shreg_q,     shreg_d;

    logic start_edge;
    logic byte_done;
    logic frame_err;

    assign start_edge = (bit_state_q == B_IDLE) && rx_prev_q && !rx_sync_q;

    always_comb begin
        bit_state_d = bit_state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        byte_done   = 1'b0;
        frame_err   = 1'b0;

        case (bit_state_q)
            B_IDLE: begin
                if (start_edge) begin
                    bit_state_d = B_START;
                    bit_cnt_d   = '0;
                end
            end

            B_START: begin
                // Mid-bit check rejects short glitches without flagging them.
                if (bit_cnt_q == HALF_LAST) begin
                    bit_cnt_d   = '0;
                    bit_idx_d   = '0;
                    bit_state_d = rx_sync_q ? B_IDLE : B_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            B_DATA: begin
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d = '0;
                    // LSB first: shift in at the top, first bit ends at bit 0.
                    shreg_d   = {rx_sync_q, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        bit_state_d = B_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            B_STOP: begin
                // Back to idle at the stop sample so a following start bit
                // with zero gap is caught by the edge detector.
                if (bit_cnt_q == BIT_LAST) begin
                    bit_cnt_d   = '0;
                    bit_state_d = B_IDLE;
                    if (rx_sync_q) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                bit_state_d = B_IDLE;
                bit_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bit_state_q <= B_IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
        end else begin
            bit_state_q <= bit_state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    frm_state_t        frm_state_q, frm_state_d;
    logic [7:0]        dev_b_q,  dev_b_d;
    logic [7:0]        mod_b_q,  mod_b_d;
    logic [7:0]        addr_b_q, addr_b_d;
    logic [7:0]        data_b_q, data_b_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic [7:0]        dev_id_q,   dev_id_d;
    logic [7:0]        mod_id_q,   mod_id_d;
    logic [7:0]        cmd_addr_q, cmd_addr_d;
    logic [7:0]        cmd_data_q, cmd_data_d;
    logic              cmd_vld_q,  cmd_vld_d;
    logic              err_chk_q,  err_chk_d;
    logic              err_frm_q,  err_frm_d;

    logic [7:0]        chk_sum;
    logic              dev_ok;

    assign chk_sum = dev_b_q + mod_b_q + addr_b_q + data_b_q;

`ifdef CTRL_RX_BROADCAST_EN
    assign dev_ok = (dev_b_q == cfg_dev_id) || (dev_b_q == 8'hFF);
`else
    assign dev_ok = (dev_b_q == cfg_dev_id);
`endif

    always_comb begin
        frm_state_d = frm_state_q;
        dev_b_d     = dev_b_q;
        mod_b_d     = mod_b_q;
        addr_b_d    = addr_b_q;
        data_b_d    = data_b_q;
        tmo_cnt_d   = tmo_cnt_q;
        dev_id_d    = dev_id_q;
        mod_id_d    = mod_id_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        cmd_vld_d   = 1'b0;
        err_chk_d   = 1'b0;
        err_frm_d   = 1'b0;

        // Inter-byte timeout only counts line-idle time inside a frame;
        // it cannot coincide with byte_done/frame_err, which need the bit
        // FSM in STOP.
        if ((frm_state_q == F_WAIT_HEAD) || start_edge) begin
            tmo_cnt_d = '0;
        end else if (bit_state_q == B_IDLE) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_cnt_d   = '0;
                frm_state_d = F_WAIT_HEAD;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end

        if (frame_err) begin
            err_frm_d   = 1'b1;
            frm_state_d = F_WAIT_HEAD;
        end else if (byte_done) begin
            case (frm_state_q)
                F_WAIT_HEAD: begin
                    if (shreg_q == HEAD) begin
                        frm_state_d = F_DEV;
                    end
                end
                F_DEV: begin
                    dev_b_d     = shreg_q;
                    frm_state_d = F_MOD;
                end
                F_MOD: begin
                    mod_b_d     = shreg_q;
                    frm_state_d = F_ADDR;
                end
                F_ADDR: begin
                    addr_b_d    = shreg_q;
                    frm_state_d = F_DATA;
                end
                F_DATA: begin
                    data_b_d    = shreg_q;
                    frm_state_d = F_CHK;
                end
                F_CHK: begin
                    frm_state_d = F_WAIT_HEAD;
                    if (shreg_q != chk_sum) begin
                        err_chk_d = 1'b1;
                    end else if (dev_ok) begin
                        dev_id_d   = dev_b_q;
                        mod_id_d   = mod_b_q;
                        cmd_addr_d = addr_b_q;
                        cmd_data_d = data_b_q;
                        cmd_vld_d  = 1'b1;
                    end
                end
                default: begin
                    frm_state_d = F_WAIT_HEAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            frm_state_q <= F_WAIT_HEAD;
            dev_b_q     <= '0;
            mod_b_q     <= '0;
            addr_b_q    <= '0;
            data_b_q    <= '0;
            tmo_cnt_q   <= '0;
            dev_id_q    <= '0;
            mod_id_q    <= '0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            cmd_vld_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_frm_q   <= 1'b0;
        end else begin
            frm_state_q <= frm_state_d;
            dev_b_q     <= dev_b_d;
            mod_b_q     <= mod_b_d;
            addr_b_q    <= addr_b_d;
            data_b_q    <= data_b_d;
            tmo_cnt_q   <= tmo_cnt_d;
            dev_id_q    <= dev_id_d;
            mod_id_q    <= mod_id_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            cmd_vld_q   <= cmd_vld_d;
            err_chk_q   <= err_chk_d;
            err_frm_q   <= err_frm_d;
        end
    end

    assign dev_id   = dev_id_q;
    assign mod_id   = mod_id_q;
    assign cmd_addr = cmd_addr_q;
    assign cmd_data = cmd_data_q;
    assign cmd_vld  = cmd_vld_q;
    assign err_chk  = err_chk_q;
    assign err_frm  = err_frm_q;

endmodule

// File: tb/tb_ctrl_rx_frame.sv
module tb_ctrl_rx_frame;

    localparam int BD  = 48;
    localparam int TMO = 2000;

    logic       clk_sys = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx_ctrl = 1'b1;
    logic [7:0] cfg_dev_id = 8'h01;
    logic [7:0] dev_id, mod_id, cmd_addr, cmd_data;
    logic       cmd_vld, err_chk, err_frm;

    ctrl_rx_frame #(
        .BIT_DIV (BD),
        .TIMEOUT (TMO),
        .HEAD    (8'hAA)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .rx_ctrl    (rx_ctrl),
        .cfg_dev_id (cfg_dev_id),
        .dev_id     (dev_id),
        .mod_id     (mod_id),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_vld    (cmd_vld),
        .err_chk    (err_chk),
        .err_frm    (err_frm)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    int n_vld = 0, n_chk = 0, n_frm = 0, n_excl = 0, vld_cyc = 0;
    always @(negedge clk_sys) begin
        if (cmd_vld) begin
            n_vld++;
            vld_cyc = cyc;
        end
        if (err_chk) n_chk++;
        if (err_frm) n_frm++;
        if ((int'(cmd_vld) + int'(err_chk) + int'(err_frm)) > 1) n_excl++;
    end

    int vecs = 0;
    int errs = 0;
    int s_vld, s_chk, s_frm;
    int last_start = 0;
    logic [7:0] e_dev, e_mod, e_addr, e_data;

    task automatic chk(input string tag, input int obs, input int exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, "_dev"},  int'(dev_id),   int'(e_dev));
        chk({tag, "_mod"},  int'(mod_id),   int'(e_mod));
        chk({tag, "_addr"}, int'(cmd_addr), int'(e_addr));
        chk({tag, "_data"}, int'(cmd_data), int'(e_data));
    endtask

    task automatic chk_strobes(input string tag, input int v, input int c, input int f);
        chk({tag, "_vld_n"}, n_vld - s_vld, v);
        chk({tag, "_chk_n"}, n_chk - s_chk, c);
        chk({tag, "_frm_n"}, n_frm - s_frm, f);
    endtask

    task automatic snap();
        s_vld = n_vld;
        s_chk = n_chk;
        s_frm = n_frm;
    endtask

    task automatic hold(input logic v, input int n);
        rx_ctrl = v;
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        last_start = cyc;
        hold(1'b0, BD);
        for (int i = 0; i < 8; i++) hold(b[i], BD);
        hold(stop, BD);
        rx_ctrl = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [7:0] m,
                              input logic [7:0] a, input logic [7:0] x,
                              input logic [7:0] c);
        send_byte(8'hAA, 1'b1);
        send_byte(d, 1'b1);
        send_byte(m, 1'b1);
        send_byte(a, 1'b1);
        send_byte(x, 1'b1);
        send_byte(c, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        // ---- reset state
        repeat (4) @(posedge clk_sys);
        #1;
        e_dev = 8'h00; e_mod = 8'h00; e_addr = 8'h00; e_data = 8'h00;
        chk_outs("rst");
        chk("rst_vld", int'(cmd_vld), 0);
        chk("rst_errchk", int'(err_chk), 0);
        chk("rst_errfrm", int'(err_frm), 0);
        rst_n = 1'b1;
        hold(1'b1, 10);

        // ---- valid frame
        snap();
        send_frame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6D);
        hold(1'b1, 20);
        chk_strobes("t1", 1, 0, 0);
        d = vld_cyc - last_start;
        chk("t1_vld_in_stop_bit", int'(d >= 9 * BD && d < 10 * BD), 1);
        e_dev = 8'h01; e_mod = 8'h02; e_addr = 8'h10; e_data = 8'h5A;
        chk_outs("t1");

        // ---- bad checksum
        snap();
        send_frame(8'h01, 8'h02, 8'h10, 8'h5A, 8'h6E);
        hold(1'b1, 20);
        chk_strobes("t2", 0, 1, 0);
        chk_outs("t2");

        // ---- other device address, silent drop
        snap();
        send_frame(8'h03, 8'h02, 8'h10, 8'h5A, 8'h6F);
        hold(1'b1, 20);
        chk_strobes("t3", 0, 0, 0);
        chk_outs("t3");

        // ---- broadcast address
        snap();
        send_frame(8'hFF, 8'h02, 8'h10, 8'h5A, 8'h6B);
        hold(1'b1, 20);
`ifdef CTRL_RX_BROADCAST_EN
        chk_strobes("t4", 1, 0, 0);
        e_dev = 8'hFF;
`else
        chk_strobes("t4", 0, 0, 0);
`endif
        chk_outs("t4");

        // ---- stop bit low on the mod byte, then a valid frame
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b0);
        hold(1'b1, 2 * BD);
        chk_strobes("t5a", 0, 0, 1);
        chk_outs("t5a");
        snap();
        send_frame(8'h01, 8'h03, 8'h20, 8'h77, 8'h9B);
        hold(1'b1, 20);
        chk_strobes("t5b", 1, 0, 0);
        e_dev = 8'h01; e_mod = 8'h03; e_addr = 8'h20; e_data = 8'h77;
        chk_outs("t5b");

        // ---- 20-cycle glitch on idle line
        snap();
        hold(1'b0, 20);
        hold(1'b1, 4 * BD);
        chk_strobes("t6", 0, 0, 0);

        // ---- inter-byte pause beyond timeout drops the frame
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        hold(1'b1, 3000);
        send_byte(8'h10, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h6D, 1'b1);
        hold(1'b1, 20);
        chk_strobes("t7a", 0, 0, 0);
        chk_outs("t7a");
        snap();
        send_frame(8'h01, 8'h04, 8'h30, 8'h11, 8'h46);
        hold(1'b1, 20);
        chk_strobes("t7b", 1, 0, 0);
        e_mod = 8'h04; e_addr = 8'h30; e_data = 8'h11;
        chk_outs("t7b");

        // ---- pause shorter than timeout keeps the frame alive
        snap();
        send_byte(8'hAA, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h40, 1'b1);
        hold(1'b1, 1500);
        send_byte(8'h22, 1'b1);
        send_byte(8'h68, 1'b1);
        hold(1'b1, 20);
        chk_strobes("t8", 1, 0, 0);
        e_mod = 8'h05; e_addr = 8'h40; e_data = 8'h22;
        chk_outs("t8");

        // ---- reset in the middle of a data byte
        send_byte(8'hAA, 1'b1);
        hold(1'b0, BD);
        hold(1'b1, BD);
        hold(1'b0, BD / 2);
        rst_n   = 1'b0;
        rx_ctrl = 1'b1;
        repeat (3) @(posedge clk_sys);
        #1;
        e_dev = 8'h00; e_mod = 8'h00; e_addr = 8'h00; e_data = 8'h00;
        chk_outs("t9rst");
        chk("t9rst_vld", int'(cmd_vld), 0);
        rst_n = 1'b1;
        hold(1'b1, 10);
        snap();
        send_frame(8'h01, 8'h06, 8'h50, 8'h33, 8'h8A);
        hold(1'b1, 20);
        chk_strobes("t9", 1, 0, 0);
        e_dev = 8'h01; e_mod = 8'h06; e_addr = 8'h50; e_data = 8'h33;
        chk_outs("t9");

        chk("strobe_exclusive", n_excl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
